// File: rtl/data_mem_if.sv
// Request/response bundle between the core's memory stage and the data-memory responder.
interface data_mem_if #(
    parameter int ADDR_W = 32
);
    logic              MemRead;
    logic              MemWr;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              stall;
    logic              done;
    logic              err;

    modport master (output MemRead, MemWr, funct3, addr, wdata,
                    input  rdata, stall, done, err);
    modport slave  (input  MemRead, MemWr, funct3, addr, wdata,
                    output rdata, stall, done, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data-memory responder: 1-cycle stores, 2-cycle loads with a one-cycle stall,
// illegal or misaligned requests rejected with an err pulse.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input logic       clk,
    input logic       n_rst,
    data_mem_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t           state, state_nxt;
    logic [3:0][7:0]  mem [DEPTH_WORDS];
    logic [31:0]      rd_word;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;

    logic             is_rd, is_wr, ld_ok, st_ok, aligned, valid;
    logic             we, re;
    logic [3:0]       be;
    logic [3:0][7:0]  wlane;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sel_b;
    logic [15:0]      sel_h;

    // Upper address bits are intentionally dropped so accesses wrap modulo the RAM size.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+2];

    assign idx   = bus.addr[IDX_W+1:2];
    assign is_rd = bus.MemRead & ~bus.MemWr;
    assign is_wr = bus.MemWr & ~bus.MemRead;

    always_comb begin
        ld_ok   = 1'b0;
        st_ok   = 1'b0;
        aligned = 1'b1;
        case (bus.funct3)
            3'b000: begin ld_ok = 1'b1; st_ok = 1'b1; end
            3'b001: begin ld_ok = 1'b1; st_ok = 1'b1; aligned = ~bus.addr[0]; end
            3'b010: begin ld_ok = 1'b1; st_ok = 1'b1; aligned = (bus.addr[1:0] == 2'b00); end
            3'b100: ld_ok = 1'b1;
            3'b101: begin ld_ok = 1'b1; aligned = ~bus.addr[0]; end
            default: ;
        endcase
        valid = ((is_rd & ld_ok) | (is_wr & st_ok)) & aligned;
    end

    // Store data is replicated across lanes; the byte enables pick the real targets.
    always_comb begin
        be    = 4'b0000;
        wlane = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << bus.addr[1:0];
                wlane = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{bus.wdata[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        re        = 1'b0;
        bus.stall = 1'b0;
        bus.err   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.MemRead | bus.MemWr) begin
                    if (!valid) begin
                        bus.err = 1'b1;
                    end else if (is_rd) begin
                        bus.stall = 1'b1;
                        re        = 1'b1;
                        state_nxt = RD_WAIT;
                    end else begin
                        we = n_rst;
                    end
                end
            end
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            off_q <= 2'b00;
            f3_q  <= 3'b000;
        end else begin
            state <= state_nxt;
            if (re) begin
                off_q <= bus.addr[1:0];
                f3_q  <= bus.funct3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int l = 0; l < 4; l++)
                if (be[l]) mem[idx][l] <= wlane[l];
        if (re)
            rd_word <= mem[idx];
    end

    // A reset asserted during RD_WAIT must suppress the pending result.
    assign bus.done = (state == RD_WAIT) && n_rst;
    assign sel_b    = rd_word[8*off_q +: 8];
    assign sel_h    = off_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.done) begin
            case (f3_q)
                3'b000:  bus.rdata = {{24{sel_b[7]}}, sel_b};
                3'b001:  bus.rdata = {{16{sel_h[15]}}, sel_h};
                3'b010:  bus.rdata = rd_word;
                3'b100:  bus.rdata = {24'h0, sel_b};
                3'b101:  bus.rdata = {16'h0, sel_h};
                default: bus.rdata = 32'h0;
            endcase
        end
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the RISC-V core: it receives the `MemRead`/`MemWr` strobes from the instruction decoder, plus the ALU address, `rs2` store data and `funct3`. It performs byte, halfword and word accesses on an internal synchronous-read word RAM. Loads take two cycles, so the block stalls the pipeline for one cycle on every load and returns sign- or zero-extended data. Stores complete in a single cycle, and illegal or misaligned requests are flagged and not executed.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the RAM (power of two, ≥4).
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  reset; one clock; reset is synchronous and active-low.
- `MemRead`  in  1  load request from the decoder.
- `MemWr`  in  1  store request from the decoder.
- `funct3`  in  3  access size and signedness, taken from the instruction.
- `addr`  in  ADDR_W  byte address from the ALU.
- `wdata`  in  32  store data (`rs2`), right-aligned.
- `rdata`  out  32  extended load result; valid only while `done`=1, otherwise 0.
- `stall`  out  1  holds PC and pipeline registers; the core keeps the request stable while this is high.
- `done`  out  1  load data valid this cycle.
- `err`  out  1  one-cycle pulse for a rejected request.

## Operation
- **funct3 encoding**
  - 000 = B (signed on load), 001 = H (signed on load), 010 = W, 100 = BU, 101 = HU.
  - BU/HU are legal only with `MemRead`; all other codes are illegal.
- **Request validity.** A request is *valid* when exactly one of `MemRead`/`MemWr` is high, `funct3` is legal for that direction, and the address is aligned.
  - H requires `addr[0]`=0.
  - W requires `addr[1:0]`=00.
- **Word index.** The index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so accesses wrap modulo the RAM size.
- **FSM states.** Two states: IDLE and RD_WAIT.
- **IDLE, valid store**
  - Writes the enabled byte lanes at the rising edge.
  - Lane enables: B → lane `addr[1:0]`, using `wdata[7:0]`. H → lanes `addr[1]*2` and `+1`, using `wdata[15:0]`. W → all four lanes.
  - `stall`=0. Stay in IDLE.
- **IDLE, valid load**
  - `stall`=1 combinationally.
  - The RAM read of the word is issued, and `addr[1:0]` and `funct3` are latched.
  - Next state: RD_WAIT.
- **RD_WAIT**
  - `stall`=0 and `done`=1.
  - `rdata` is the lane selected by the latched offset, extended by the latched `funct3`: sign-extended for B/H, zero-extended for BU/HU, full word for W.
  - Unconditionally return to IDLE.
  - The request still present on the inputs in this cycle is the one already serviced; it is never re-issued.
- **Invalid request (IDLE only)**
  - `err`=1 for that cycle, `stall`=0.
  - No RAM write and no state change.
  - Both strobes high is invalid.
- **No request.** Neither strobe high: outputs idle.
- **Reset**
  - While `n_rst`=0 at the edge: state returns to IDLE, latches clear, and no RAM write occurs.
  - After that edge, `stall`/`done`/`err`=0 and `rdata`=0.
  - Reset during RD_WAIT abandons the load, and `done` is never raised for it.
  - RAM contents are not reset.
- **Write/read collision.** Not possible, because a load and a store never occupy the same cycle.

## Timing
- Store latency: 1 cycle; data is visible to a load issued in the next cycle.
- Load latency: request in cycle N (`stall`=1), data in cycle N+1 (`done`=1, `stall`=0). The core advances at the end of N+1.
- Back-to-back loads: each costs 2 cycles with no bubble beyond the stall.
- A store in the cycle immediately after RD_WAIT is accepted.
- Output sources:
  - `stall` and `err` are combinational from state and inputs.
  - `done` is decoded from state.
  - `rdata` is combinational from the RAM output register and the latched offset/size.

## Test plan
- **SW then LW.** Store word 0xDEADBEEF to 0x10, then LW from 0x10 → `stall`=1 for one cycle, then `done`=1 with `rdata`=0xDEADBEEF.
- **SB and byte loads.** SB 0x80 to 0x21, then LB 0x21 → 0xFFFFFF80. LBU 0x21 → 0x00000080. LW 0x20 → the other lanes are unchanged.
- **Misaligned and illegal requests.** Each of the following → `err` pulses one cycle, `stall`=0, and a following LW shows the RAM unchanged:
  - LH at 0x03.
  - SW at 0x02.
  - `funct3`=100 with `MemWr`.
  - Both strobes high.
- **Reset mid-load.** LW issued, then `n_rst`=0 during RD_WAIT → `done` never asserts; next cycle `stall`/`done`/`err`/`rdata`=0.
- **Wrap and back-to-back loads.** With `DEPTH_WORDS`=1024, SW to 0x1000 aliases word 0, so LW 0x0 returns the stored value. Back-to-back LH 0x2 / LHU 0x2 of 0x8001 → 0xFFFF8001 and then 0x00008001, each with exactly one stall cycle.
